display_button_scanner: RTL
===========================

# display_button_scanner

- Reads the Cambridge display board push-buttons through the board's parallel-in/serial-out shift-register chain (SHIFT_LOAD, SHIFT_CLKIN, SHIFT_OUT).
- Debounces each button and presents a stable, active-high button word plus per-button press pulses.
- Sits directly upstream of the toplevel user logic (LED/counter logic in the CLOCK_50 domain), replacing raw pin reads.

## Interface
Parameters:
- NBITS, 16: number of bits in the shift chain (buttons).
- CLK_DIV, 25: CLOCK_50 cycles per shift tick; SHIFT_CLKIN half-period. Must be ≥ 2.
- DEBOUNCE_SCANS, 4: consecutive disagreeing scans needed to change a debounced bit. Must be ≥ 1.

Ports:
- CLOCK_50, input, 1: sole clock; all logic on posedge.
- rst_n, input, 1: asynchronous, active-low reset.
- enable, input, 1: 1 = scan continuously; 0 = finish the current scan, then idle.
- SHIFT_LOAD, output, 1: active-low parallel load to the chain.
- SHIFT_CLKIN, output, 1: shift clock to the chain.
- SHIFT_OUT, input, 1: serial data from the chain. Low = button pressed.
- buttons, output, NBITS: debounced state. 1 = pressed.
- pressed, output, NBITS: one-cycle pulse per bit on a debounced 0→1 transition.
- scan_done, output, 1: one-cycle pulse when a scan completes and buttons/pressed update.

## Operation
- Tick generator:
  - Counter 0..CLK_DIV-1, free-running while not in IDLE.
  - tick asserts when the counter equals CLK_DIV-1.
  - The counter is held at 0 in IDLE.
- FSM states:
  - IDLE:
    - Outputs: SHIFT_LOAD=1, SHIFT_CLKIN=0.
    - If enable=1, go to LOAD next cycle.
  - LOAD:
    - Outputs: SHIFT_LOAD=0, SHIFT_CLKIN=0.
    - On tick, go to SHIFT_LO with bit index = NBITS-1.
  - SHIFT_LO:
    - Outputs: SHIFT_LOAD=1, SHIFT_CLKIN=0.
    - On tick, sample ~SHIFT_OUT into raw[index], drive SHIFT_CLKIN=1, go to SHIFT_HI.
  - SHIFT_HI:
    - Output: SHIFT_CLKIN=1.
    - On tick, drive SHIFT_CLKIN=0.
    - If index=0, go to DONE; else decrement index and go to SHIFT_LO.
  - DONE:
    - Lasts one cycle; performs the debounce update and asserts scan_done.
    - Next state is LOAD if enable=1, else IDLE.
- Bit order: the first sampled bit is raw[NBITS-1]; the last sampled bit is raw[0].
- The final SHIFT_HI ends with SHIFT_CLKIN low. The extra trailing edge is harmless; the chain is reloaded next.
- Debounce, per bit i, evaluated in DONE only:
  - If raw[i]==buttons[i]: cnt[i] ← 0.
  - Else if cnt[i]==DEBOUNCE_SCANS-1: buttons[i] ← raw[i], cnt[i] ← 0.
  - Else: cnt[i] ← cnt[i]+1.
  - cnt width is $clog2(DEBOUNCE_SCANS)+1; the counter saturates and never wraps.
- pressed[i] = 1 in DONE exactly when buttons[i] goes 0→1; 0 at all other times.
- Release (1→0) updates buttons with no pulse.
- Deasserting enable mid-scan does not abort; the scan completes and DONE runs normally.
- Reasserting enable in DONE keeps scanning with no IDLE cycle.

## Timing
- Reset values:
  - SHIFT_LOAD=1, SHIFT_CLKIN=0.
  - buttons=0, pressed=0, scan_done=0.
  - All cnt=0; raw=0; tick counter=0; state=IDLE.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). Partial raw data is discarded; there is no scan_done.
- Outputs are registered; there is no combinational path from SHIFT_OUT or enable to any output.
- Scan period with enable held high: (1 + 2·NBITS)·CLK_DIV + 1 cycles. Defaults: 33·25+1 = 826 cycles.
- First scan_done after rst_n deasserts with enable=1: IDLE (1) + LOAD..SHIFT (33·25) + DONE → pulse in cycle 826 after the first active edge.
- SHIFT_OUT is sampled at the end of each SHIFT_LO half-period, i.e. CLK_DIV cycles after the preceding falling SHIFT_CLKIN or load release.
- Press latency: a new level is reflected on buttons in the DONE of the DEBOUNCE_SCANS-th consecutive scan that sees it.
- scan_done and pressed are asserted in the same cycle as the buttons update.

## Test plan
- Reset/idle:
  - Stimulus: rst_n low, then high with enable=0 for 2000 cycles.
  - Required: SHIFT_LOAD=1, SHIFT_CLKIN=0 throughout; buttons=0; no scan_done.
- Single press with bench 16-bit PISO model (defaults):
  - Stimulus: hold bit 5 pressed from time 0.
  - Required: scan_done every 826 cycles; buttons=16'h0020 and pressed=16'h0020 on the 4th scan_done; pressed=0 on the 5th.
- Bounce rejection:
  - Stimulus: bit 3 alternates pressed/released every scan for 10 scans.
  - Required: buttons[3] stays 0; no pressed pulse.
- Release and multi-bit:
  - Stimulus: bits 0 and 15 pressed for 6 scans, then released.
  - Required: buttons=16'h8001 with pressed=16'h8001 at scan 4; buttons=0 at scan 10; no pulse on release.
- enable drop mid-scan:
  - Stimulus: enable→0 during SHIFT_HI of bit 8.
  - Required: remaining bits shift out; one scan_done; then IDLE with SHIFT_LOAD=1.
- Async reset mid-scan:
  - Stimulus: rst_n pulsed low for 3 cycles during shifting while buttons=16'h0020.
  - Required: outputs at reset values immediately; the next scan starts from LOAD; buttons returns to 16'h0020 only after 4 further scans.

Source files
------------

// File: rtl/display_button_scanner.sv
// -----------------------------------------------------------------------------
// display_button_scanner
//
// Scans the display board push-buttons through the board's parallel-in /
// serial-out shift-register chain. It debounces each button and presents a
// stable active-high button word, together with one-cycle press pulses.
//
// Ports
//   CLOCK_50    in   1      sole clock; all logic on posedge
//   rst_n       in   1      asynchronous active-low reset
//   enable      in   1      1 = scan continuously, 0 = finish scan then idle
//   SHIFT_LOAD  out  1      active-low parallel load to the chain
//   SHIFT_CLKIN out  1      shift clock to the chain
//   SHIFT_OUT   in   1      serial data from the chain (low = pressed)
//   buttons     out  NBITS  debounced state (1 = pressed)
//   pressed     out  NBITS  one-cycle pulse on a debounced 0->1 transition
//   scan_done   out  1      one-cycle pulse when buttons/pressed update
// -----------------------------------------------------------------------------
module display_button_scanner #(
    parameter int NBITS          = 16,
    parameter int CLK_DIV        = 25,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             CLOCK_50,
    input  logic             rst_n,
    input  logic             enable,
    output logic             SHIFT_LOAD,
    output logic             SHIFT_CLKIN,
    input  logic             SHIFT_OUT,
    output logic [NBITS-1:0] buttons,
    output logic [NBITS-1:0] pressed,
    output logic             scan_done
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NBITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_SHIFT_LO = 3'd2,
        S_SHIFT_HI = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [DIV_W-1:0]              r_div;
    logic [DIV_W-1:0]              w_div_next;
    logic                          w_tick;
    logic [IDX_W-1:0]              r_idx;
    logic [IDX_W-1:0]              w_idx_next;
    logic [NBITS-1:0]              r_raw;
    logic [NBITS-1:0]              w_raw_next;
    logic [NBITS-1:0][CNT_W-1:0]   r_cnt;
    logic [NBITS-1:0][CNT_W-1:0]   w_cnt_next;
    logic [NBITS-1:0]              r_buttons;
    logic [NBITS-1:0]              w_buttons_next;
    logic [NBITS-1:0]              r_pressed;
    logic [NBITS-1:0]              w_pressed_next;
    logic                          r_scan_done;
    logic                          w_enter_done;
    logic                          r_shift_load;
    logic                          r_shift_clkin;

    assign w_tick       = (r_div == DIV_LAST);
    // DONE is only ever entered from the last SHIFT_HI, so this is a one-cycle
    // strobe; updating on entry makes the new values visible during DONE.
    assign w_enter_done = (w_next_state == S_DONE);

    // Next-state, tick counter, bit index and raw capture.
    always_comb begin
        w_next_state = r_state;
        w_div_next   = {DIV_W{1'b0}};
        w_idx_next   = r_idx;
        w_raw_next   = r_raw;
        case (r_state)
            S_IDLE: begin
                if (enable) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_LOAD: begin
                w_div_next = w_tick ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
                if (w_tick) begin
                    w_next_state = S_SHIFT_LO;
                    w_idx_next   = IDX_TOP;
                end else begin
                    w_next_state = S_LOAD;
                end
            end
            S_SHIFT_LO: begin
                w_div_next = w_tick ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
                if (w_tick) begin
                    // Chain output is active-low; store as 1 = pressed.
                    w_raw_next[r_idx] = ~SHIFT_OUT;
                    w_next_state      = S_SHIFT_HI;
                end else begin
                    w_next_state = S_SHIFT_LO;
                end
            end
            S_SHIFT_HI: begin
                w_div_next = w_tick ? {DIV_W{1'b0}} : r_div + DIV_W'(1);
                if (w_tick) begin
                    if (r_idx == {IDX_W{1'b0}}) begin
                        w_next_state = S_DONE;
                    end else begin
                        w_idx_next   = r_idx - IDX_W'(1);
                        w_next_state = S_SHIFT_LO;
                    end
                end else begin
                    w_next_state = S_SHIFT_HI;
                end
            end
            S_DONE: begin
                // Counter stays at 0 so the next LOAD lasts a full tick.
                if (enable) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Per-bit debounce counters, debounced word and press pulses.
    always_comb begin
        w_cnt_next     = r_cnt;
        w_buttons_next = r_buttons;
        w_pressed_next = {NBITS{1'b0}};
        if (w_enter_done) begin
            for (int i = 0; i < NBITS; i++) begin
                if (r_raw[i] == r_buttons[i]) begin
                    w_cnt_next[i] = {CNT_W{1'b0}};
                end else if (r_cnt[i] >= CNT_MAX) begin
                    w_buttons_next[i] = r_raw[i];
                    w_cnt_next[i]     = {CNT_W{1'b0}};
                    // Pulse only on press; a release updates silently.
                    w_pressed_next[i] = r_raw[i];
                end else begin
                    w_cnt_next[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end else begin
            w_cnt_next     = r_cnt;
            w_buttons_next = r_buttons;
        end
    end

    // State, tick counter, index and raw registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_div   <= {DIV_W{1'b0}};
            r_idx   <= {IDX_W{1'b0}};
            r_raw   <= {NBITS{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_div   <= w_div_next;
            r_idx   <= w_idx_next;
            r_raw   <= w_raw_next;
        end
    end

    // Debounce state and user-facing result registers.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= {(NBITS*CNT_W){1'b0}};
            r_buttons   <= {NBITS{1'b0}};
            r_pressed   <= {NBITS{1'b0}};
            r_scan_done <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_next;
            r_buttons   <= w_buttons_next;
            r_pressed   <= w_pressed_next;
            r_scan_done <= w_enter_done;
        end
    end

    // Chain control pins, registered from the next state so they match it.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            r_shift_load  <= 1'b1;
            r_shift_clkin <= 1'b0;
        end else begin
            r_shift_load  <= (w_next_state != S_LOAD);
            r_shift_clkin <= (w_next_state == S_SHIFT_HI);
        end
    end

    assign SHIFT_LOAD  = r_shift_load;
    assign SHIFT_CLKIN = r_shift_clkin;
    assign buttons     = r_buttons;
    assign pressed     = r_pressed;
    assign scan_done   = r_scan_done;

endmodule
